// File: rtl/meter_peak_accum.sv
// Peak-hold accumulator: tracks per-meter |sample| peaks with periodic decay and
// mirrors every updated peak into the metering memory. Sweeps all peaks to zero on reset/clear.
module meter_peak_accum #(
    parameter int unsigned DATA_WIDTH   = 24,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DECAY_PERIOD = 480,
    parameter int unsigned DECAY_SHIFT  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_en,
    input  logic                  clear,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_en
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned FCNT_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
    logic                    busy_q;
    logic                    out_en_q;
    logic [ADDR_WIDTH-1:0]   out_addr_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [FCNT_W-1:0]       fcnt_q;
    logic                    decay_active_q;
    logic                    s1_valid_q;
    logic [ADDR_WIDTH-1:0]   s1_addr_q;
    logic [DATA_WIDTH-1:0]   s1_mag_q;
    logic                    s1_decay_q;
    logic                    fwd_q;
    logic [DATA_WIDTH-1:0]   fwd_data_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic [DATA_WIDTH-1:0]   ram_q [DEPTH];

    logic [DATA_WIDTH-1:0]   mag_c;
    logic [DATA_WIDTH-1:0]   old_c;
    logic [DATA_WIDTH-1:0]   step_c;
    logic [DATA_WIDTH-1:0]   decayed_c;
    logic [DATA_WIDTH-1:0]   peak_d;
    logic                    ram_we_c;
    logic [ADDR_WIDTH-1:0]   ram_waddr_c;
    logic [DATA_WIDTH-1:0]   ram_wdata_c;

    assign busy     = busy_q;
    assign out_en   = out_en_q;
    assign out_addr = out_addr_q;
    assign out_data = out_data_q;
    assign sweep_d  = sweep_q + ADDR_WIDTH'(1);

    // Saturating magnitude so the most negative sample still fits DATA_WIDTH-1 bits
    always_comb begin
        mag_c = in_data;
        if (in_data == MIN_NEG) begin
            mag_c = MAX_POS;
        end else if (in_data[DATA_WIDTH-1]) begin
            mag_c = (~in_data) + DATA_WIDTH'(1);
        end
    end

    // S1: old peak (forwarded when S1 wrote the same meter last cycle), decay, then max
    always_comb begin
        old_c  = fwd_q ? fwd_data_q : rd_data_q;
        step_c = old_c >> DECAY_SHIFT;
        if (step_c == '0) begin
            step_c = DATA_WIDTH'(1);
        end
        decayed_c = old_c;
        if (s1_decay_q) begin
            decayed_c = (old_c != '0) ? (old_c - step_c) : '0;
        end
        peak_d = (s1_mag_q > decayed_c) ? s1_mag_q : decayed_c;
    end

    always_comb begin
        ram_we_c    = 1'b0;
        ram_waddr_c = sweep_q;
        ram_wdata_c = '0;
        if (!clear) begin
            if (state_q == ST_CLEAR) begin
                ram_we_c = 1'b1;
            end else if (s1_valid_q) begin
                ram_we_c    = 1'b1;
                ram_waddr_c = s1_addr_q;
                ram_wdata_c = peak_d;
            end
        end
    end

    // Peak RAM: one write port, synchronous read, contents not reset
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            ram_q[ram_waddr_c] <= ram_wdata_c;
        end
        rd_data_q <= ram_q[in_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_CLEAR;
            sweep_q        <= '0;
            busy_q         <= 1'b1;
            out_en_q       <= 1'b0;
            out_addr_q     <= '0;
            out_data_q     <= '0;
            fcnt_q         <= '0;
            decay_active_q <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_addr_q      <= '0;
            s1_mag_q       <= '0;
            s1_decay_q     <= 1'b0;
            fwd_q          <= 1'b0;
            fwd_data_q     <= '0;
        end else begin
            // Frame counter keeps running regardless of FSM state
            if (sample_tick) begin
                if (fcnt_q == FCNT_W'(DECAY_PERIOD - 1)) begin
                    fcnt_q         <= '0;
                    decay_active_q <= 1'b1;
                end else begin
                    fcnt_q         <= fcnt_q + FCNT_W'(1);
                    decay_active_q <= 1'b0;
                end
            end

            out_en_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            fwd_q      <= 1'b0;

            case (state_q)
                ST_CLEAR: begin
                    if (clear) begin
                        sweep_q <= '0;
                    end else begin
                        out_en_q   <= 1'b1;
                        out_addr_q <= sweep_q;
                        out_data_q <= '0;
                        sweep_q    <= sweep_d;
                        if (&sweep_q) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (clear) begin
                        state_q <= ST_CLEAR;
                        sweep_q <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        if (s1_valid_q) begin
                            out_en_q   <= 1'b1;
                            out_addr_q <= s1_addr_q;
                            out_data_q <= peak_d;
                        end
                        if (in_en) begin
                            s1_valid_q <= 1'b1;
                            s1_addr_q  <= in_addr;
                            s1_mag_q   <= mag_c;
                            s1_decay_q <= decay_active_q;
                            fwd_q      <= s1_valid_q && (s1_addr_q == in_addr);
                            fwd_data_q <= peak_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    sweep_q <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule
